// File: rtl/key4x4_emu_pkg.sv
// Shared definitions for the 4x4 keypad emulator: phase encodings, code slicing and 50 MHz timing.
package key4x4_emu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAKE  = 3'd1,
    S_HOLD  = 3'd2,
    S_BREAK = 3'd3,
    S_GAP   = 3'd4
  } emu_state_t;

  // Press timing at a 50 MHz system clock.
  localparam int DEF_CNT_W          = 22;
  localparam int DEF_HOLD_CYC       = 2_500_000;
  localparam int DEF_BOUNCE_PERIOD  = 50_000;
  localparam int DEF_BOUNCE_TOGGLES = 4;
  localparam int DEF_GAP_CYC        = 1_250_000;

  function automatic logic [1:0] code_row(input logic [3:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] code_col(input logic [3:0] code);
    return code[1:0];
  endfunction

endpackage

// File: rtl/key4x4_emu_timer.sv
// Phase timer: loadable down-counter that parks at zero; tc is high while the count is zero.
module key4x4_emu_timer #(
  parameter int CNT_W = 22
) (
  input  logic             CLOCK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/key4x4_emu_module.sv
// Passive 4x4 key-matrix emulator: turns requested key codes into timed, optionally bouncing presses
// by routing the selected row drive onto the selected column line.
module key4x4_emu_module
  import key4x4_emu_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int HOLD_CYC       = DEF_HOLD_CYC,
  parameter int BOUNCE_PERIOD  = DEF_BOUNCE_PERIOD,
  parameter int BOUNCE_TOGGLES = DEF_BOUNCE_TOGGLES,
  parameter int GAP_CYC        = DEF_GAP_CYC
) (
  input  logic       CLOCK,
  input  logic       RST,
  input  logic [3:0] key_out_x,
  output logic [3:0] key_in_y,
  input  logic       req_valid,
  input  logic [3:0] req_code,
  output logic       req_ready,
  output logic       busy,
  output logic       done,
  output emu_state_t dbg_state
);

  // Handshake: a request is taken on any edge where req_valid and req_ready are both high;
  // req_ready is high only in IDLE, and requests presented while busy are dropped, never queued.

  if (HOLD_CYC < 1 || 64'(HOLD_CYC) >= (64'd1 << CNT_W) ||
      GAP_CYC < 1 || 64'(GAP_CYC) >= (64'd1 << CNT_W) ||
      BOUNCE_TOGGLES < 0 ||
      (BOUNCE_TOGGLES > 0 && (BOUNCE_PERIOD < 1 || 64'(BOUNCE_PERIOD) >= (64'd1 << CNT_W))))
  begin : g_bad_params
    $error("key4x4_emu_module: cycle counts must be in 1 .. 2**CNT_W-1");
  end

  localparam int K_W        = (BOUNCE_TOGGLES > 1) ? $clog2(BOUNCE_TOGGLES) : 1;
  localparam bit NO_BOUNCE  = (BOUNCE_TOGGLES == 0);
  localparam logic [K_W-1:0]   LAST_K    = K_W'((BOUNCE_TOGGLES > 0) ? BOUNCE_TOGGLES - 1 : 0);
  localparam logic [CNT_W-1:0] LD_BOUNCE = CNT_W'((BOUNCE_PERIOD > 0) ? BOUNCE_PERIOD - 1 : 0);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(GAP_CYC - 1);

  emu_state_t       state;
  logic [K_W-1:0]   bounce_k;
  logic [1:0]       row;
  logic [1:0]       col;
  logic             last_k;
  logic             contact;
  logic [3:0]       col_next;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tc;

  key4x4_emu_timer #(.CNT_W(CNT_W)) u_timer (
    .CLOCK    (CLOCK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  // The timer is reloaded on every phase entry and bounce-interval boundary with the next length - 1.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = LD_BOUNCE;
    last_k   = (bounce_k == LAST_K);
    case (state)
      S_IDLE: if (req_valid) begin
        tmr_load = 1'b1;
        tmr_val  = NO_BOUNCE ? LD_HOLD : LD_BOUNCE;
      end
      S_MAKE: if (tc) begin
        tmr_load = 1'b1;
        tmr_val  = last_k ? LD_HOLD : LD_BOUNCE;
      end
      S_HOLD: if (tc) begin
        tmr_load = 1'b1;
        tmr_val  = NO_BOUNCE ? LD_GAP : LD_BOUNCE;
      end
      S_BREAK: if (tc) begin
        tmr_load = 1'b1;
        tmr_val  = last_k ? LD_GAP : LD_BOUNCE;
      end
      default: ;
    endcase
  end

  // Make bounce closes on even intervals, break bounce closes on odd ones.
  always_comb begin
    contact  = (state == S_HOLD) ||
               (state == S_MAKE  && !bounce_k[0]) ||
               (state == S_BREAK &&  bounce_k[0]);
    col_next = 4'b1111;
    if (contact) col_next[col] = key_out_x[row];
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state    <= S_IDLE;
      bounce_k <= '0;
      row      <= '0;
      col      <= '0;
      done     <= 1'b0;
      key_in_y <= 4'b1111;
    end else begin
      done     <= 1'b0;
      key_in_y <= col_next;
      case (state)
        S_IDLE: if (req_valid) begin
          row      <= code_row(req_code);
          col      <= code_col(req_code);
          bounce_k <= '0;
          state    <= NO_BOUNCE ? S_HOLD : S_MAKE;
        end
        S_MAKE: if (tc) begin
          if (last_k) begin
            bounce_k <= '0;
            state    <= S_HOLD;
          end else begin
            bounce_k <= bounce_k + K_W'(1);
          end
        end
        S_HOLD: if (tc) begin
          bounce_k <= '0;
          state    <= NO_BOUNCE ? S_GAP : S_BREAK;
        end
        S_BREAK: if (tc) begin
          if (last_k) begin
            bounce_k <= '0;
            state    <= S_GAP;
          end else begin
            bounce_k <= bounce_k + K_W'(1);
          end
        end
        S_GAP: if (tc) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_key4x4_emu_module.sv
// Bench for key4x4_emu_module: a bouncing and a clean-contact instance share one stimulus stream
// and are compared each cycle against a press-timeline model.
module tb_key4x4_emu_module;
  import key4x4_emu_pkg::*;

  localparam int HOLD = 20;
  localparam int BP   = 3;
  localparam int TOGA = 2;
  localparam int GAP  = 5;

  logic       CLOCK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] key_out_x = 4'b1111;
  logic       req_valid = 1'b0;
  logic [3:0] req_code = 4'd0;

  logic [3:0] key_a, key_b;
  logic       ready_a, ready_b, busy_a, busy_b, done_a, done_b;
  emu_state_t dbg_a, dbg_b;

  int total = 0;
  int bad = 0;
  int n = 0;

  bit         act[2];
  int         ps[2];
  int         rw[2];
  int         cl[2];
  bit         closed[2];
  int         done_n[2];

  always #5 CLOCK = ~CLOCK;

  key4x4_emu_module #(.CNT_W(22), .HOLD_CYC(HOLD), .BOUNCE_PERIOD(BP),
                      .BOUNCE_TOGGLES(TOGA), .GAP_CYC(GAP)) dut_a (
    .CLOCK(CLOCK), .RST(RST), .key_out_x(key_out_x), .key_in_y(key_a),
    .req_valid(req_valid), .req_code(req_code), .req_ready(ready_a),
    .busy(busy_a), .done(done_a), .dbg_state(dbg_a));

  key4x4_emu_module #(.CNT_W(22), .HOLD_CYC(HOLD), .BOUNCE_PERIOD(BP),
                      .BOUNCE_TOGGLES(0), .GAP_CYC(GAP)) dut_b (
    .CLOCK(CLOCK), .RST(RST), .key_out_x(key_out_x), .key_in_y(key_b),
    .req_valid(req_valid), .req_code(req_code), .req_ready(ready_b),
    .busy(busy_b), .done(done_b), .dbg_state(dbg_b));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic int plen(input int t);
    return 2 * t * BP + HOLD + GAP;
  endfunction

  // Contact state in press cycle p (0 = first cycle after the accepting edge).
  function automatic bit contact_at(input int p, input int t);
    int b;
    b = t * BP;
    if (p < b) return ((p / BP) % 2) == 0;
    if (p < b + HOLD) return 1'b1;
    if (p < 2 * b + HOLD) return ((p - b - HOLD) / BP) % 2 == 1;
    return 1'b0;
  endfunction

  task automatic step(input bit r, input bit v, input logic [3:0] c, input logic [3:0] kx);
    RST = r;
    req_valid = v;
    req_code = c;
    key_out_x = kx;
    @(posedge CLOCK);
    #1;
    n++;
    for (int d = 0; d < 2; d++) begin
      int t;
      logic [3:0] k;
      bit e_done;
      logic [3:0] got_key;
      logic got_done, got_ready, got_busy;
      t = (d == 0) ? TOGA : 0;
      k = 4'b1111;
      if (closed[d]) k[cl[d]] = kx[rw[d]];
      e_done = 1'b0;
      if (r) begin
        act[d] = 1'b0;
        k = 4'b1111;
      end else if (act[d] && (n - ps[d] == plen(t))) begin
        act[d] = 1'b0;
        e_done = 1'b1;
      end else if (!act[d] && v) begin
        act[d] = 1'b1;
        ps[d] = n;
        rw[d] = int'(c[3:2]);
        cl[d] = int'(c[1:0]);
      end
      closed[d] = act[d] && contact_at(n - ps[d], t);
      got_key   = (d == 0) ? key_a : key_b;
      got_done  = (d == 0) ? done_a : done_b;
      got_ready = (d == 0) ? ready_a : ready_b;
      got_busy  = (d == 0) ? busy_a : busy_b;
      if (got_done === 1'b1) done_n[d] = n;
      check($sformatf("key_in_y%0d", d), {4'd0, got_key}, {4'd0, k});
      check($sformatf("done%0d", d), {7'd0, got_done}, {7'd0, e_done});
      check($sformatf("req_ready%0d", d), {7'd0, got_ready}, {7'd0, !act[d]});
      check($sformatf("busy%0d", d), {7'd0, got_busy}, {7'd0, act[d]});
    end
  endtask

  function automatic logic [3:0] scan_row(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (i % 4));
  endfunction

  initial begin
    int acc;
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; ps[d] = 0; rw[d] = 0; cl[d] = 0; closed[d] = 1'b0; done_n[d] = -1;
    end

    // reset, then idle
    step(1'b1, 1'b0, 4'd0, 4'b1111);
    step(1'b1, 1'b1, 4'd3, 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd9, scan_row(i));

    // row1 col2 with a rotating scanner; both instances accept on the same edge
    step(1'b0, 1'b1, 4'd6, scan_row(0));
    acc = ps[0];
    for (int i = 1; i < 46; i++) step(1'b0, 1'b0, 4'd6, scan_row(i));
    check("latency_bounce", 8'(done_n[0] - acc), 8'(plen(TOGA)));
    check("latency_clean", 8'(done_n[1] - acc), 8'(plen(0)));

    // row0 col0 held low: bounce pattern on column 0
    step(1'b0, 1'b1, 4'd0, 4'b1110);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 4'd0, 4'b1110);

    // row3 col3 on the clean instance path, plus reset in the middle of HOLD
    step(1'b0, 1'b1, 4'd15, 4'b0111);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 4'd15, 4'b0111);
    step(1'b1, 1'b0, 4'd15, 4'b0111);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 4'd15, 4'b0111);

    // req_valid held high with changing codes
    for (int i = 0; i < 200; i++)
      step(1'b0, 1'b1, 4'($urandom_range(0, 15)), scan_row(i));

    // fully random traffic, including all-high and multi-row-low drives
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] kx;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6) kx = scan_row(i);
      else if (sel < 8) kx = 4'($urandom_range(0, 15));
      else kx = 4'b1111;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
           4'($urandom_range(0, 15)), kx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
